// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, MSB first.
// Latency: done pulses N cycles after the accepting edge; one result per N+2 cycles.
// Backpressure: start is honoured only while ready=1; requests during RUN/DONE are dropped.
module seq_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         dbz
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  rem;
    logic [N-1:0]  rem_nxt;
    logic [N-1:0]  qsh;
    logic [N-1:0]  qsh_nxt;
    logic [N-1:0]  dvs;
    logic [CW-1:0] cnt;
    logic          dbz_r;
    logic [N:0]    shifted;
    logic [N:0]    trial;

    // The partial remainder is always below the divisor (or holds a prefix of a
    // when dividing by zero), so its top bit is structurally zero and not stored.
    always_comb begin
        shifted = {rem, qsh[N-1]};
        trial   = shifted - {1'b0, dvs};
        if (!trial[N]) begin
            rem_nxt = trial[N-1:0];
            qsh_nxt = {qsh[N-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[N-1:0];
            qsh_nxt = {qsh[N-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem   <= '0;
            qsh   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            dbz_r <= 1'b0;
            q     <= '0;
            r     <= '0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rem   <= '0;
                        qsh   <= a;
                        dvs   <= b;
                        cnt   <= CW'(N - 1);
                        dbz_r <= (b == '0);
                    end
                end
                RUN: begin
                    rem <= rem_nxt;
                    qsh <= qsh_nxt;
                    if (cnt == '0) begin
                        q   <= qsh_nxt;
                        r   <= rem_nxt;
                        dbz <= dbz_r;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
